// File: rtl/bcd_mult_sequencer_pkg.sv
// Shared widths, indices and state encodings for the 2-digit BCD transform multiplier.
package bcd_mult_sequencer_pkg;

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned MUL_W  = 6;
  localparam int unsigned PROD_W = 12;
  // Wide enough for 4*c_k built from arbitrary 12-bit products.
  localparam int unsigned COEF_W = 15;

  localparam logic [2:0] MUL_LAST   = 3'd5;
  localparam logic [1:0] CARRY_LAST = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StEval   = 3'd1;
  localparam state_t StMul    = 3'd2;
  localparam state_t StInterp = 3'd3;
  localparam state_t StScale  = 3'd4;
  localparam state_t StCarry  = 3'd5;
  localparam state_t StDone   = 3'd6;

  function automatic logic digit_bad(input logic [DIG_W-1:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_carry.sv
// One decimal carry step: (coefficient, carry in) -> (BCD digit, carry out).
module bcd_digit_carry
  import bcd_mult_sequencer_pkg::*;
(
  input  logic [COEF_W-1:0] coef_i,
  input  logic [COEF_W-1:0] carry_i,
  output logic [DIG_W-1:0]  digit_o,
  output logic [COEF_W-1:0] carry_o
);

  logic [COEF_W-1:0] sum;

  always_comb begin
    sum     = coef_i + carry_i;
    digit_o = DIG_W'(sum % COEF_W'(10));
    carry_o = sum / COEF_W'(10);
  end

endmodule

// File: rtl/bcd_mult_sequencer.sv
// Multi-cycle controller: evaluate at {1,-1,i,-i}, six shared products, interpolate, carry.
module bcd_mult_sequencer
  import bcd_mult_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*DIG_W-1:0]   a_bcd,
  input  logic [2*DIG_W-1:0]   b_bcd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4*DIG_W-1:0]   product_bcd,
  output logic                 mul_req,
  output logic [MUL_W-1:0]     mul_a,
  output logic [MUL_W-1:0]     mul_b,
  input  logic                 mul_gnt,
  input  logic [PROD_W-1:0]    mul_p
);

  state_t                    state_q, state_d;
  logic [DIG_W-1:0]          a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic [MUL_W-1:0]          ap_q, ap_d, am_q, am_d, bp_q, bp_d, bm_q, bm_d;
  logic [2:0]                k_q, k_d;
  logic [1:0]                j_q, j_d;
  logic signed [PROD_W-1:0]  p_q [6];
  logic signed [PROD_W-1:0]  p_d [6];
  logic signed [COEF_W-1:0]  coef_q [4];
  logic signed [COEF_W-1:0]  coef_d [4];
  logic [COEF_W-1:0]         carry_q, carry_d;
  logic [4*DIG_W-1:0]        prod_q, prod_d;
  logic                      err_q, err_d;

  logic signed [COEF_W-1:0]  sum01, dif01, re2, im2;
  logic [MUL_W-1:0]          sel_a, sel_b;
  logic [DIG_W-1:0]          digit;
  logic [COEF_W-1:0]         carry_out;

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign mul_req     = (state_q == StMul);
  assign err         = err_q;
  assign product_bcd = prod_q;

  // Products are signed; the LHS width sign-extends before the add/sub.
  assign sum01 = p_q[0] + p_q[1];
  assign dif01 = p_q[0] - p_q[1];
  assign re2   = (p_q[2] - p_q[3]) <<< 1;
  assign im2   = (p_q[4] + p_q[5]) <<< 1;

  bcd_digit_carry u_carry (
    .coef_i  (coef_q[j_q]),
    .carry_i (carry_q),
    .digit_o (digit),
    .carry_o (carry_out)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    case (k_q)
      3'd0:    begin sel_a = ap_q;          sel_b = bp_q;          end
      3'd1:    begin sel_a = am_q;          sel_b = bm_q;          end
      3'd2:    begin sel_a = MUL_W'(a0_q);  sel_b = MUL_W'(b0_q);  end
      3'd3:    begin sel_a = MUL_W'(a1_q);  sel_b = MUL_W'(b1_q);  end
      3'd4:    begin sel_a = MUL_W'(a0_q);  sel_b = MUL_W'(b1_q);  end
      3'd5:    begin sel_a = MUL_W'(a1_q);  sel_b = MUL_W'(b0_q);  end
      default: ;
    endcase
    mul_a = mul_req ? sel_a : '0;
    mul_b = mul_req ? sel_b : '0;
  end

  always_comb begin
    state_d = state_q;
    a0_d = a0_q; a1_d = a1_q; b0_d = b0_q; b1_d = b1_q;
    ap_d = ap_q; am_d = am_q; bp_d = bp_q; bm_d = bm_q;
    k_d = k_q;
    j_d = j_q;
    p_d = p_q;
    coef_d = coef_q;
    carry_d = carry_q;
    prod_d = prod_q;
    err_d = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a0_d = a_bcd[DIG_W-1:0];
          a1_d = a_bcd[2*DIG_W-1:DIG_W];
          b0_d = b_bcd[DIG_W-1:0];
          b1_d = b_bcd[2*DIG_W-1:DIG_W];
          err_d = 1'b0;
          state_d = StEval;
        end
      end
      StEval: begin
        ap_d = MUL_W'(a0_q) + MUL_W'(a1_q);
        am_d = MUL_W'(a0_q) - MUL_W'(a1_q);
        bp_d = MUL_W'(b0_q) + MUL_W'(b1_q);
        bm_d = MUL_W'(b0_q) - MUL_W'(b1_q);
        k_d = '0;
        if (digit_bad(a0_q) || digit_bad(a1_q) || digit_bad(b0_q) || digit_bad(b1_q)) begin
          err_d = 1'b1;
          prod_d = '0;
          state_d = StDone;
        end else begin
          state_d = StMul;
        end
      end
      StMul: begin
        if (mul_gnt) begin
          p_d[k_q] = $signed(mul_p);
          if (k_q == MUL_LAST) state_d = StInterp;
          else                 k_d = k_q + 3'd1;
        end
      end
      StInterp: begin
        coef_d[0] = sum01 + re2;
        coef_d[1] = dif01 + im2;
        coef_d[2] = sum01 - re2;
        coef_d[3] = dif01 - im2;
        state_d = StScale;
      end
      StScale: begin
        for (int i = 0; i < 4; i++) begin
          if (coef_q[i][1:0] != 2'b00) err_d = 1'b1;
          coef_d[i] = coef_q[i] >>> 2;
        end
        j_d = '0;
        carry_d = '0;
        state_d = StCarry;
      end
      StCarry: begin
        prod_d[{j_q, 2'b00} +: DIG_W] = digit;
        carry_d = carry_out;
        if (j_q == CARRY_LAST) state_d = StDone;
        else                   j_d = j_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a0_q <= '0; a1_q <= '0; b0_q <= '0; b1_q <= '0;
      ap_q <= '0; am_q <= '0; bp_q <= '0; bm_q <= '0;
      k_q <= '0;
      j_q <= '0;
      for (int i = 0; i < 6; i++) p_q[i] <= '0;
      for (int i = 0; i < 4; i++) coef_q[i] <= '0;
      carry_q <= '0;
      prod_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a0_q <= a0_d; a1_q <= a1_d; b0_q <= b0_d; b1_q <= b1_d;
      ap_q <= ap_d; am_q <= am_d; bp_q <= bp_d; bm_q <= bm_d;
      k_q <= k_d;
      j_q <= j_d;
      for (int i = 0; i < 6; i++) p_q[i] <= p_d[i];
      for (int i = 0; i < 4; i++) coef_q[i] <= coef_d[i];
      carry_q <= carry_d;
      prod_q <= prod_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_bcd_mult_sequencer.sv
// Scoreboard bench: driver pushes expected results, a negedge monitor pops on done and compares.
module tb_bcd_mult_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a_bcd, b_bcd;
  logic        busy, done, err;
  logic [15:0] product_bcd;
  logic        mul_req;
  logic [5:0]  mul_a, mul_b;
  logic        mul_gnt;
  logic [11:0] mul_p;

  bcd_mult_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_bcd       (a_bcd),
    .b_bcd       (b_bcd),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .product_bcd (product_bcd),
    .mul_req     (mul_req),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_gnt     (mul_gnt),
    .mul_p       (mul_p)
  );

  // Behavioural shared multiplier.
  assign mul_p = $signed({{6{mul_a[5]}}, mul_a}) * $signed({{6{mul_b[5]}}, mul_b});

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gcnt = 0;
  int   stalls = 0;
  int   force_stalls = 0;
  bit   rand_gnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit bad_op(input logic [7:0] x);
    return (x[3:0] > 4'd9) || (x[7:4] > 4'd9);
  endfunction

  function automatic logic [15:0] model_prod(input logic [7:0] a, input logic [7:0] b);
    int da, db, p;
    logic [15:0] r;
    if (bad_op(a) || bad_op(b)) return 16'h0000;
    da = int'(a[7:4]) * 10 + int'(a[3:0]);
    db = int'(b[7:4]) * 10 + int'(b[3:0]);
    p = da * db;
    r = {4'(p / 1000), 4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10)};
    return r;
  endfunction

  // Operand of the idx-th pointwise product, from the evaluation-point definitions.
  function automatic int opnd(input logic [7:0] x, input int idx, input bit is_b);
    int x0, x1;
    x0 = int'(x[3:0]);
    x1 = int'(x[7:4]);
    case (idx)
      0: return x0 + x1;
      1: return x0 - x1;
      2: return x0;
      3: return x1;
      4: return is_b ? x1 : x0;
      default: return is_b ? x0 : x1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Grant driver and monitor share one negedge process so the grant seen is the one driven.
  initial begin
    mul_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        gcnt = 0;
        stalls = 0;
        mul_gnt = 1'b0;
      end else begin
        if (mul_req && force_stalls > 0) begin
          mul_gnt = 1'b0;
          force_stalls--;
        end else if (rand_gnt) begin
          mul_gnt = ($urandom_range(0, 3) != 0);
        end else begin
          mul_gnt = 1'b1;
        end
        if (mul_req) begin
          if (sb.size() == 0) begin
            fail_event("mul_req_without_op");
          end else if (gcnt < 6) begin
            check("mul_a", int'($signed(mul_a)), opnd(sb[0].a, gcnt, 1'b0));
            check("mul_b", int'($signed(mul_b)), opnd(sb[0].b, gcnt, 1'b1));
            if (mul_gnt) gcnt++;
            else         stalls++;
          end else begin
            fail_event("mul_req_after_six_grants");
          end
        end
        if (done) begin
          if (sb.size() == 0) begin
            fail_event("unexpected_done");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("product_bcd", int'(product_bcd), int'(e.prod));
            check("err", int'(err), int'(e.err));
            check("latency", cyc - e.acc + 1, (e.err ? 2 : 14) + stalls);
            check("grant_count", gcnt, e.err ? 0 : 6);
            check("busy_at_done", int'(busy), 1);
          end
          gcnt = 0;
          stalls = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail_event("timeout_waiting_for_done");
      sb.delete();
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.a = a;
    e.b = b;
    e.prod = model_prod(a, b);
    e.err = bad_op(a) || bad_op(b);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int nstall,
                        input bit poke);
    force_stalls = nstall;
    issue(a, b);
    if (poke) begin
      // Start raised while busy must be ignored.
      a_bcd = 8'($urandom);
      b_bcd = 8'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    start = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    #23;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_mul_req", int'(mul_req), 0);
    check("reset_product", int'(product_bcd), 0);
    check("reset_mul_a", int'(mul_a), 0);
    check("reset_mul_b", int'(mul_b), 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(8'h58, 8'h76, 0, 1'b0);
    run_op(8'h99, 8'h99, 0, 1'b0);
    run_op(8'h00, 8'h37, 0, 1'b0);
    run_op(8'h12, 8'h34, 3, 1'b0);
    run_op(8'h5A, 8'h21, 0, 1'b1);
    run_op(8'h47, 8'h83, 0, 1'b1);

    // Reset in the middle of MUL.
    issue(8'h99, 8'h88);
    n = 0;
    while (!mul_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reached_mul", int'(mul_req), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mul_req", int'(mul_req), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_product", int'(product_bcd), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    run_op(8'h25, 8'h04, 0, 1'b0);

    rand_gnt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b;
      a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 7) == 0) a[3:0] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) b[7:4] = 4'($urandom_range(10, 15));
      run_op(a, b, 0, ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
